uart_tx_arb: RTL and testbench
==============================

# uart_tx_arb

Round-robin arbiter that shares a single `uart_tx` transmitter among N byte-stream requesters, such as the RX-loopback FIFO, a status reporter and a debug port. Each requester offers bytes on a valid/ready handshake. The arbiter accepts one byte, latches it, pulses `tx_start`, and waits for `tx_done_tick` before granting again. It sits between the requesters and `uart_tx` and replaces ad-hoc tx_start sequencing in the top level.

## Interface
Parameters:
- `N`, default 4: number of requesters, 2..8.
- `DBIT`, default 8: data bits per character; must match `uart_tx`.

Ports:
- `clk`  in  1: system clock; all logic is on the rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `req_valid`  in  N: requester i has a byte on its data slice.
- `req_data`  in  N*DBIT: byte for requester i on bits `[i*DBIT +: DBIT]`.
- `req_last`  in  N: byte is the last of a packet; only used under `UART_ARB_PKT_LOCK_EN`.
- `req_ready`  out  N: one-hot accept; the byte is transferred on any edge where `req_valid[i] & req_ready[i]`.
- `tx_start`  out  1: one-cycle start pulse to `uart_tx`.
- `tx_din`  out  DBIT: latched byte to `uart_tx`; stable from `tx_start` until `tx_done_tick`.
- `tx_done_tick`  in  1: one-cycle completion pulse from `uart_tx`.
- `grant_id`  out  clog2(N): index of the requester owning the current or most recent transfer.
- `busy`  out  1: high in the START and WAIT states.

## Operation
FSM states and transitions:
- IDLE: if any `req_valid`, select a winner (rules below), assert its `req_ready`, latch `tx_din` and `grant_id`, and go to START. Otherwise stay in IDLE.
- START: `tx_start` = 1 for exactly this cycle, then go to WAIT.
- WAIT: on `tx_done_tick`, update the priority pointer and go to IDLE. Otherwise stay in WAIT.

Arbitration and handshake rules:
- Winner is the first requester with valid set, searching from `ptr+1` upward and wrapping modulo N. After a completed transfer, `ptr` becomes the winner's index.
- `req_ready` is combinational from state, `req_valid` and `ptr`. It is at most one-hot and is 0 outside IDLE.
- Requesters must hold `req_data` stable while `req_valid` is high and not yet accepted. `req_valid` is never required to drop.
- `tx_done_tick` is ignored in IDLE and START.
- Wrap-around: with `ptr` = N-1, the search starts at requester 0.

Reset values, applied asynchronously:
- state = IDLE, `tx_start` = 0, `tx_din` = 0, `grant_id` = 0, `busy` = 0, `req_ready` = 0.
- `ptr` = N-1, so requester 0 has first priority.
- Lock is cleared.

Reset mid-transfer aborts the transfer. The byte already accepted is dropped; it is not re-offered.

## Timing
- The handshake occurs at edge t. `tx_start` is high in cycle t+1 and `busy` is high from t+1.
- `tx_done_tick` arrives in cycle d. The FSM is back in IDLE at d+1, and `req_ready` can assert in d+1.
- Minimum gap from `tx_done_tick` to the next `tx_start` is 2 cycles, so back-to-back characters incur a 2-clock penalty. This is negligible against a 16-tick bit period.
- `tx_din` and `grant_id` are registered and change only on an accept edge.

## Configuration
The single compile-time option is `UART_ARB_PKT_LOCK_EN`.
- Defined:
  - A lock flag is set when an accepted byte has `req_last` = 0, and is cleared when an accepted byte has `req_last` = 1.
  - While locked, IDLE considers only `grant_id`. Other requesters see `req_ready` = 0 even if the locked requester is idle.
  - `ptr` updates only when the lock clears.
  - Packets from different requesters are never interleaved.
- Undefined: `req_last` is ignored and arbitration is per byte.

## Test plan
- Reset, then `req_valid` = 4'b0001 with `req_data[7:0]` = 8'h41:
  - `req_ready` = 4'b0001 in the same cycle.
  - `tx_start` pulses one cycle later with `tx_din` = 8'h41 and `grant_id` = 0.
  - `busy` stays high until `tx_done_tick`.
- All four requesters valid continuously, with bytes 8'hA0..8'hA3: transmit order is 0,1,2,3,0, each after the prior `tx_done_tick`.
- Requester 2 is the only one valid after requester 3 was served: requester 2 wins.
- Requester 3 wins with `ptr` = 2; next, requesters 0 and 3 are valid: requester 0 wins (wrap-around).
- `tx_done_tick` injected while the FSM is in START: ignored. The FSM stays in WAIT until the next `tx_done_tick`.
- Reset asserted during WAIT: all outputs return to reset values within the same cycle. The next grant goes to requester 0.
- With `UART_ARB_PKT_LOCK_EN` defined:
  - Requester 1 sends 3 bytes with `req_last` = 0,0,1 while requester 0 is valid throughout.
  - Required response: all three bytes from requester 1 are sent consecutively, then requester 0 is served.

Source files
------------

// File: rtl/uart_tx_arb_if.sv
// Handshake bundle between N byte requesters, the uart_tx_arb arbiter and the uart_tx transmitter.
// slave = arbiter side, master = requester/transmitter side.
interface uart_tx_arb_if #(
    parameter int N    = 4,
    parameter int DBIT = 8
);
    localparam int IW = $clog2(N);

    logic [N-1:0]      req_valid;
    logic [N*DBIT-1:0] req_data;
    logic [N-1:0]      req_last;
    logic [N-1:0]      req_ready;
    logic              tx_start;
    logic [DBIT-1:0]   tx_din;
    logic              tx_done_tick;
    logic [IW-1:0]     grant_id;
    logic              busy;

    modport slave (
        input  req_valid, req_data, req_last, tx_done_tick,
        output req_ready, tx_start, tx_din, grant_id, busy
    );

    modport master (
        output req_valid, req_data, req_last, tx_done_tick,
        input  req_ready, tx_start, tx_din, grant_id, busy
    );
endinterface

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter sharing one uart_tx among N byte requesters; packet lock under UART_ARB_PKT_LOCK_EN.
// Latency: accept at edge t, tx_start in t+1; back in IDLE the cycle after tx_done_tick.
// Backpressure: req_ready is held low from accept until the transmitter reports done.
module uart_tx_arb #(
    parameter int N    = 4,
    parameter int DBIT = 8
) (
    input  logic          i_clk,
    input  logic          i_rst,
    uart_tx_arb_if.slave  bus
);
    localparam int IW = $clog2(N);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_WAIT
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [IW-1:0]   r_ptr;
    logic [IW-1:0]   r_grant;
    logic [DBIT-1:0] r_din;
    logic [IW-1:0]   w_win;
    logic [IW-1:0]   w_idx;
    logic            w_found;
    logic            w_accept;
    logic            w_done;

`ifdef UART_ARB_PKT_LOCK_EN
    logic            r_lock;
`else
    logic            w_unused_last;
    assign w_unused_last = ^bus.req_last;
`endif

    // Search starts one past the last winner so every requester gets a turn.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        for (int k = 1; k <= N; k++) begin
            w_idx = IW'((int'(r_ptr) + k) % N);
            if (!w_found && bus.req_valid[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
`ifdef UART_ARB_PKT_LOCK_EN
        if (r_lock) begin
            w_found = bus.req_valid[r_grant];
            w_win   = r_grant;
        end
`endif
    end

    assign w_accept = (r_state == S_IDLE) && w_found && !i_rst;
    assign w_done   = (r_state == S_WAIT) && bus.tx_done_tick;

    always_comb begin
        bus.req_ready = '0;
        if (w_accept) begin
            bus.req_ready[w_win] = 1'b1;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        bus.tx_start = 1'b0;
        bus.busy     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                bus.tx_start = 1'b1;
                bus.busy     = 1'b1;
                w_state_nxt  = S_WAIT;
            end
            S_WAIT: begin
                bus.busy = 1'b1;
                if (bus.tx_done_tick) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_ptr   <= IW'(N - 1);
            r_grant <= '0;
            r_din   <= '0;
`ifdef UART_ARB_PKT_LOCK_EN
            r_lock  <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_grant <= w_win;
                r_din   <= bus.req_data[int'(w_win)*DBIT +: DBIT];
`ifdef UART_ARB_PKT_LOCK_EN
                r_lock  <= !bus.req_last[w_win];
`endif
            end
`ifdef UART_ARB_PKT_LOCK_EN
            // Pointer only moves once the whole packet has gone out.
            if (w_done && !r_lock) begin
                r_ptr <= r_grant;
            end
`else
            if (w_done) begin
                r_ptr <= r_grant;
            end
`endif
        end
    end

    assign bus.tx_din   = r_din;
    assign bus.grant_id = r_grant;
endmodule

// File: tb/tb_uart_tx_arb.sv
// Bench for uart_tx_arb: per-requester byte queues, a uart_tx stand-in, and a scoreboard of expected (grant, byte) starts.
module tb_uart_tx_arb;
    localparam int N    = 4;
    localparam int DBIT = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    uart_tx_arb_if #(.N(N), .DBIT(DBIT)) arb_if ();

    uart_tx_arb #(.N(N), .DBIT(DBIT)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (arb_if)
    );

    logic [8:0] bq [N][$];
    logic [9:0] sb [$];
    int         n_chk = 0;
    int         n_err = 0;
    int         done_dly = 4;
    int         done_cnt = 0;
    bit         inj_done = 0;
    bit         chk_inj  = 0;
    bit         chk_idle = 0;
    logic [7:0] cur_din = 8'h00;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push(input int r, input logic [7:0] b, input bit last);
        bq[r].push_back({last, b});
    endtask

    task automatic expect_tx(input int g, input logic [7:0] b);
        sb.push_back({g[1:0], b});
    endtask

    function automatic int pending();
        int s = 0;
        for (int i = 0; i < N; i++) s += bq[i].size();
        return s;
    endfunction

    task automatic drive_reqs();
        for (int i = 0; i < N; i++) begin
            if (bq[i].size() != 0) begin
                arb_if.req_valid[i]            = 1'b1;
                arb_if.req_data[i*DBIT +: DBIT] = bq[i][0][7:0];
                arb_if.req_last[i]             = bq[i][0][8];
            end else begin
                arb_if.req_valid[i]            = 1'b0;
                arb_if.req_data[i*DBIT +: DBIT] = 8'h00;
                arb_if.req_last[i]             = 1'b0;
            end
        end
    endtask

    // Requesters and uart_tx stand-in: handshake sampled at the edge, inputs updated 1ns later.
    initial begin : drv
        logic [N-1:0] hs;
        logic [9:0]   e;
        arb_if.req_valid    = '0;
        arb_if.req_data     = '0;
        arb_if.req_last     = '0;
        arb_if.tx_done_tick = 1'b0;
        forever begin
            @(posedge clk);
            hs = arb_if.req_valid & arb_if.req_ready;
            #1;
            for (int i = 0; i < N; i++) begin
                if (hs[i] && bq[i].size() != 0) void'(bq[i].pop_front());
            end
            drive_reqs();
            if (chk_idle) begin
                chk("idle_after_done", 32'(arb_if.busy), 32'd0);
                chk_idle = 0;
            end
            if (chk_inj) begin
                chk("inj_done_ignored", 32'(arb_if.busy), 32'd1);
                chk_inj = 0;
            end
            arb_if.tx_done_tick = 1'b0;
            if (rst) begin
                done_cnt = 0;
            end else begin
                if (done_cnt > 0) begin
                    done_cnt--;
                    if (done_cnt == 0) begin
                        arb_if.tx_done_tick = 1'b1;
                        chk_idle = 1;
                        chk("din_stable", 32'(arb_if.tx_din), 32'(cur_din));
                    end
                end
                if (arb_if.tx_start) begin
                    chk("start_expected", 32'(sb.size() != 0), 32'd1);
                    if (sb.size() != 0) begin
                        e = sb.pop_front();
                        cur_din = e[7:0];
                        chk("grant_id", 32'(arb_if.grant_id), 32'(e[9:8]));
                        chk("tx_din", 32'(arb_if.tx_din), 32'(e[7:0]));
                    end
                    if (inj_done) begin
                        arb_if.tx_done_tick = 1'b1;
                        inj_done = 0;
                        chk_inj  = 1;
                    end
                    done_cnt = done_dly;
                end
            end
        end
    end

    // Handshake invariants every cycle.
    initial begin : inv
        forever begin
            @(negedge clk);
            if (!rst) begin
                chk("rdy_onehot0", 32'($onehot0(arb_if.req_ready)), 32'd1);
                if (arb_if.busy) chk("rdy_busy", 32'(arb_if.req_ready), 32'd0);
            end
        end
    end

    task automatic wait_drain(input string tag);
        int cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while ((sb.size() != 0 || pending() != 0 || arb_if.busy || done_cnt != 0) && cyc < 2000);
        @(negedge clk);
        chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
        chk({tag, "_reqs_left"}, 32'(pending()), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ready"}, 32'(arb_if.req_ready), 32'd0);
        chk({tag, "_start"}, 32'(arb_if.tx_start), 32'd0);
        chk({tag, "_din"},   32'(arb_if.tx_din), 32'd0);
        chk({tag, "_gid"},   32'(arb_if.grant_id), 32'd0);
        chk({tag, "_busy"},  32'(arb_if.busy), 32'd0);
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", n_chk, n_err);
        $fatal(1, "watchdog");
    end

    initial begin : main
        int cyc;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk_reset_vals("rst");
        rst = 1'b0;
        @(negedge clk);

        // Single byte from requester 0.
        push(0, 8'h41, 1'b1);
        expect_tx(0, 8'h41);
        @(negedge clk);
        chk("s1_ready_same_cycle", 32'(arb_if.req_ready), 32'b0001);
        chk("s1_busy_idle", 32'(arb_if.busy), 32'd0);
        @(negedge clk);
        chk("s1_start", 32'(arb_if.tx_start), 32'd1);
        chk("s1_busy_start", 32'(arb_if.busy), 32'd1);
        @(negedge clk);
        chk("s1_start_one_cycle", 32'(arb_if.tx_start), 32'd0);
        chk("s1_busy_wait", 32'(arb_if.busy), 32'd1);
        wait_drain("s1");

        // All four valid continuously: 0,1,2,3,0.
        do_reset();
        push(0, 8'hA0, 1'b1); push(0, 8'hA0, 1'b1);
        push(1, 8'hA1, 1'b1); push(2, 8'hA2, 1'b1); push(3, 8'hA3, 1'b1);
        expect_tx(0, 8'hA0); expect_tx(1, 8'hA1); expect_tx(2, 8'hA2);
        expect_tx(3, 8'hA3); expect_tx(0, 8'hA0);
        wait_drain("s2");

        // Requester 3 served, then requester 2 alone wins.
        push(3, 8'hB3, 1'b1); expect_tx(3, 8'hB3);
        wait_drain("s3a");
        push(2, 8'hB2, 1'b1); expect_tx(2, 8'hB2);
        wait_drain("s3b");

        // Requester 3 wins from ptr=2, then 0 beats 3 by wrap-around.
        push(3, 8'hC3, 1'b1); expect_tx(3, 8'hC3);
        wait_drain("s4a");
        push(0, 8'hC0, 1'b1); push(3, 8'hC4, 1'b1);
        expect_tx(0, 8'hC0); expect_tx(3, 8'hC4);
        wait_drain("s4b");

        // tx_done_tick during START is ignored.
        inj_done = 1;
        push(1, 8'hD1, 1'b1); expect_tx(1, 8'hD1);
        wait_drain("s5");

        // Reset during WAIT aborts; next grant goes to requester 0.
        done_dly = 30;
        push(2, 8'hE2, 1'b1); expect_tx(2, 8'hE2);
        cyc = 0;
        while (sb.size() != 0 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        repeat (3) @(negedge clk);
        chk("s6_busy_before_rst", 32'(arb_if.busy), 32'd1);
        rst = 1'b1;
        #1;
        chk_reset_vals("s6_rst");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        done_dly = 4;
        @(negedge clk);
        push(3, 8'hF3, 1'b1); push(0, 8'hF0, 1'b1);
        expect_tx(0, 8'hF0); expect_tx(3, 8'hF3);
        wait_drain("s6");

`ifdef UART_ARB_PKT_LOCK_EN
        // Packet from requester 1 is not interleaved with requester 0.
        do_reset();
        push(0, 8'h50, 1'b1); expect_tx(0, 8'h50);
        wait_drain("s7a");
        push(1, 8'h61, 1'b0); push(1, 8'h62, 1'b0); push(1, 8'h63, 1'b1);
        push(0, 8'h51, 1'b1);
        expect_tx(1, 8'h61); expect_tx(1, 8'h62); expect_tx(1, 8'h63);
        expect_tx(0, 8'h51);
        wait_drain("s7b");
`endif

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
